// File: rtl/reimu_ctrl_pkg.sv
// rtl/reimu_ctrl_pkg.sv - shared player-state encoding, screen geometry and clamp helper
package reimu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_DEAD   = 2'd1,
        ST_INVULN = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;

    // Sprite half-sizes; the pixel mux draws the 30x50 sprite around the centre.
    localparam logic [9:0] HALF_W = 10'd15;
    localparam logic [9:0] HALF_H = 10'd25;

    localparam logic [9:0] X_MIN = HALF_W;
    localparam logic [9:0] X_MAX = H_ACTIVE - HALF_W - 10'd1;
    localparam logic [9:0] Y_MIN = HALF_H;
    localparam logic [9:0] Y_MAX = V_ACTIVE - HALF_H;

    // One axis of movement: opposing buttons cancel, result saturates at [lo, hi].
    function automatic logic [9:0] step_axis(
        input logic [9:0] pos,
        input logic       dec,
        input logic       inc,
        input logic [3:0] step,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        logic signed [10:0] sum;
        sum = $signed({1'b0, pos});
        if (dec && !inc) begin
            sum = sum - $signed({7'd0, step});
        end else if (inc && !dec) begin
            sum = sum + $signed({7'd0, step});
        end
        if (sum < $signed({1'b0, lo})) begin
            return lo;
        end else if (sum > $signed({1'b0, hi})) begin
            return hi;
        end
        return sum[9:0];
    endfunction

endpackage

// File: rtl/reimu_ctrl_if.sv
// rtl/reimu_ctrl_if.sv - video timing, buttons and hit in; player position/state out
interface reimu_ctrl_if;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_slow;
    logic       hit;
    logic [9:0] reimux;
    logic [9:0] reimuy;
    logic       reimuE;
    logic [1:0] lives;
    logic       invuln;
    logic       game_over;

    modport master (
        output hc, vc, btn_up, btn_down, btn_left, btn_right, btn_slow, hit,
        input  reimux, reimuy, reimuE, lives, invuln, game_over
    );

    modport slave (
        input  hc, vc, btn_up, btn_down, btn_left, btn_right, btn_slow, hit,
        output reimux, reimuy, reimuE, lives, invuln, game_over
    );
endinterface

// File: rtl/reimu_ctrl_btn_sync.sv
// rtl/reimu_ctrl_btn_sync.sv - 2-flop synchronizer bank for the raw board buttons
module reimu_ctrl_btn_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk_25m,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;
endmodule

// File: rtl/reimu_ctrl.sv
// rtl/reimu_ctrl.sv - player movement and lives/death/respawn FSM, updated once per frame in vblank
// Optional build macro REIMU_BLINK_EN: blink reimuE during post-respawn invulnerability.
module reimu_ctrl
    import reimu_ctrl_pkg::*;
#(
    parameter int SPEED_FAST    = 4,
    parameter int SPEED_SLOW    = 2,
    parameter int START_X       = 320,
    parameter int START_Y       = 400,
    parameter int DEAD_FRAMES   = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int LIVES_INIT    = 3
) (
    input  logic         clk_25m,
    input  logic         rst,
    reimu_ctrl_if.slave  bus
);
    localparam int CNT_MAX = (DEAD_FRAMES > INVULN_FRAMES) ? DEAD_FRAMES : INVULN_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_FRAMES - 1);
    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [9:0]       SPAWN_X     = 10'(START_X);
    localparam logic [9:0]       SPAWN_Y     = 10'(START_Y);

    logic [4:0]       w_btn;
    logic             w_up, w_down, w_left, w_right, w_slow;
    logic [3:0]       w_step;
    logic [9:0]       w_move_x, w_move_y;
    logic             w_blink_vis;

    logic             r_frame_tick;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_lives, w_lives_nxt;
    logic [9:0]       r_x, w_x_nxt;
    logic [9:0]       r_y, w_y_nxt;

    reimu_ctrl_btn_sync #(.WIDTH(5)) u_btn_sync (
        .clk_25m (clk_25m),
        .rst     (rst),
        .i_async ({bus.btn_slow, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up}),
        .o_sync  (w_btn)
    );

    assign {w_slow, w_right, w_left, w_down, w_up} = w_btn;

    assign w_step   = w_slow ? SPEED_SLOW[3:0] : SPEED_FAST[3:0];
    assign w_move_x = step_axis(r_x, w_left, w_right, w_step, X_MIN, X_MAX);
    assign w_move_y = step_axis(r_y, w_up,   w_down,  w_step, Y_MIN, Y_MAX);

    // Tick lands the cycle after the first vblank pixel, so position settles in vblank.
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= (bus.hc == 10'd0) && (bus.vc == V_ACTIVE);
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_state <= ST_ALIVE;
            r_cnt   <= '0;
            r_lives <= LIVES_INIT[1:0];
            r_x     <= SPAWN_X;
            r_y     <= SPAWN_Y;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lives <= w_lives_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lives_nxt = r_lives;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            ST_ALIVE: begin
                // A hit takes priority over a coincident frame tick.
                if (bus.hit) begin
                    w_cnt_nxt = '0;
                    if (r_lives > 2'd1) begin
                        w_state_nxt = ST_DEAD;
                        w_lives_nxt = r_lives - 2'd1;
                    end else begin
                        w_state_nxt = ST_OVER;
                        w_lives_nxt = 2'd0;
                    end
                end else if (r_frame_tick) begin
                    w_x_nxt = w_move_x;
                    w_y_nxt = w_move_y;
                end
            end
            ST_DEAD: begin
                if (r_frame_tick) begin
                    if (r_cnt == DEAD_LAST) begin
                        w_state_nxt = ST_INVULN;
                        w_cnt_nxt   = '0;
                        w_x_nxt     = SPAWN_X;
                        w_y_nxt     = SPAWN_Y;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_INVULN: begin
                if (r_frame_tick) begin
                    w_x_nxt = w_move_x;
                    w_y_nxt = w_move_y;
                    if (r_cnt == INVULN_LAST) begin
                        w_state_nxt = ST_ALIVE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_OVER: begin
            end
            default: begin
                w_state_nxt = ST_ALIVE;
            end
        endcase
    end

`ifdef REIMU_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_PERIOD = CNT_W'(BLINK_FRAMES);

    logic             r_blink;
    logic             w_blink_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_blink_nxt = r_blink;
        if (r_state == ST_DEAD && r_frame_tick && r_cnt == DEAD_LAST) begin
            w_blink_nxt = 1'b1;
        end else if (r_state == ST_INVULN && r_frame_tick && r_cnt != INVULN_LAST &&
                     (w_cnt_inc % BLINK_PERIOD) == '0) begin
            w_blink_nxt = ~r_blink;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_blink <= 1'b1;
        end else begin
            r_blink <= w_blink_nxt;
        end
    end

    assign w_blink_vis = r_blink;
`else
    assign w_blink_vis = 1'b1;
`endif

    assign bus.reimux    = r_x;
    assign bus.reimuy    = r_y;
    assign bus.reimuE    = (r_state == ST_ALIVE) || ((r_state == ST_INVULN) && w_blink_vis);
    assign bus.lives     = r_lives;
    assign bus.invuln    = (r_state == ST_INVULN);
    assign bus.game_over = (r_state == ST_OVER);
endmodule

// File: tb/tb_reimu_ctrl.sv
// tb/tb_reimu_ctrl.sv - directed + randomized bench for reimu_ctrl against a per-frame player model
module tb_reimu_ctrl;
    localparam int SX = 320;
    localparam int SY = 400;

    logic clk_25m = 1'b0;
    logic rst     = 1'b1;

    reimu_ctrl_if bus ();

    reimu_ctrl dut (
        .clk_25m (clk_25m),
        .rst     (rst),
        .bus     (bus)
    );

    always #20 clk_25m = ~clk_25m;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 alive, 1 dead, 2 invulnerable, 3 game over; ticks = frames spent in mode.
    int m_x, m_y, m_lives, m_mode, m_ticks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int exp_vis();
        if (m_mode == 0) return 1;
        if (m_mode == 2) begin
`ifdef REIMU_BLINK_EN
            return (((m_ticks / 8) % 2) == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_x = SX; m_y = SY; m_lives = 3; m_mode = 0; m_ticks = 0;
    endtask

    task automatic model_hit();
        if (m_mode == 0) begin
            if (m_lives > 1) begin
                m_lives--; m_mode = 1; m_ticks = 0;
            end else begin
                m_lives = 0; m_mode = 3;
            end
        end
    endtask

    task automatic model_tick(input int u, input int d, input int l, input int r, input int s);
        int step;
        step = (s != 0) ? 2 : 4;
        if (m_mode == 0 || m_mode == 2) begin
            if (r != 0 && l == 0) m_x = clamp(m_x + step, 15, 624);
            if (l != 0 && r == 0) m_x = clamp(m_x - step, 15, 624);
            if (d != 0 && u == 0) m_y = clamp(m_y + step, 25, 455);
            if (u != 0 && d == 0) m_y = clamp(m_y - step, 25, 455);
        end
        if (m_mode == 1) begin
            m_ticks++;
            if (m_ticks == 60) begin
                m_x = SX; m_y = SY; m_mode = 2; m_ticks = 0;
            end
        end else if (m_mode == 2) begin
            m_ticks++;
            if (m_ticks == 120) begin
                m_mode = 0; m_ticks = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_x"},      32'(bus.reimux),    m_x);
        check({tag, "_y"},      32'(bus.reimuy),    m_y);
        check({tag, "_E"},      32'(bus.reimuE),    exp_vis());
        check({tag, "_lives"},  32'(bus.lives),     m_lives);
        check({tag, "_invuln"}, 32'(bus.invuln),    (m_mode == 2) ? 1 : 0);
        check({tag, "_over"},   32'(bus.game_over), (m_mode == 3) ? 1 : 0);
    endtask

    // Video counters parked anywhere except (hc=0, vc=480).
    task automatic noise();
        bus.hc = 10'($urandom_range(1, 799));
        bus.vc = 10'($urandom_range(0, 524));
    endtask

    task automatic do_frame(input string tag, input int u, input int d, input int l, input int r,
                            input int s, input int rnd_hit, input int hit_on_tick);
        @(negedge clk_25m);
        bus.btn_up = (u != 0); bus.btn_down = (d != 0); bus.btn_left = (l != 0);
        bus.btn_right = (r != 0); bus.btn_slow = (s != 0);
        bus.hit = (rnd_hit != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        noise();
        repeat (3) begin
            @(negedge clk_25m);
            noise();
        end
        bus.hc = 10'd0;
        bus.vc = 10'd480;
        @(negedge clk_25m);
        noise();
        bus.hit = (hit_on_tick != 0);
        check({tag, "_hold_x"}, 32'(bus.reimux), m_x);
        check({tag, "_hold_y"}, 32'(bus.reimuy), m_y);
        check({tag, "_hold_E"}, 32'(bus.reimuE), exp_vis());
        @(negedge clk_25m);
        bus.hit = 1'b0;
        noise();
        if (hit_on_tick != 0) model_hit();
        else model_tick(u, d, l, r, s);
        check_all(tag);
    endtask

    task automatic rnd_frame(input string tag, input int rnd_hit);
        do_frame(tag, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), rnd_hit, 0);
    endtask

    task automatic hit_pulse(input string tag);
        @(negedge clk_25m);
        noise();
        bus.hit = 1'b1;
        @(negedge clk_25m);
        bus.hit = 1'b0;
        noise();
        model_hit();
        check_all(tag);
    endtask

    task automatic respawn(input string tag);
        for (int i = 0; i < 60; i++) rnd_frame({tag, "_dead"}, 1);
        check({tag, "_spawn_x"}, 32'(bus.reimux), SX);
        check({tag, "_spawn_y"}, 32'(bus.reimuy), SY);
        check({tag, "_spawn_inv"}, 32'(bus.invuln), 1);
        for (int i = 0; i < 120; i++) rnd_frame({tag, "_inv"}, 1);
        check({tag, "_alive_inv"}, 32'(bus.invuln), 0);
        check({tag, "_alive_E"}, 32'(bus.reimuE), 1);
    endtask

    initial begin
        bus.hc = 10'd5; bus.vc = 10'd5; bus.hit = 1'b0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0; bus.btn_slow = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk_25m);
        model_reset();
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) do_frame("right", 0, 0, 0, 1, 0, 0, 0);
        check("right3_x", 32'(bus.reimux), 332);

        for (int i = 0; i < 5; i++) do_frame("left_to322", 0, 0, 1, 0, 1, 0, 0);
        check("at322_x", 32'(bus.reimux), 322);
        for (int i = 0; i < 200; i++) do_frame("left_sat", 1, 1, 1, 0, 1, 0, 0);
        check("sat_x", 32'(bus.reimux), 15);
        check("updown_y", 32'(bus.reimuy), SY);

        for (int i = 0; i < 40; i++) rnd_frame("rnd_move", 0);

        hit_pulse("hit1");
        check("hit1_lives", 32'(bus.lives), 2);
        respawn("life2");

        do_frame("hit2_tick", 0, 0, 0, 1, 0, 0, 1);
        check("hit2_lives", 32'(bus.lives), 1);
        respawn("life1");

        hit_pulse("hit3");
        check("over_flag", 32'(bus.game_over), 1);
        for (int i = 0; i < 5; i++) rnd_frame("over", 1);

        @(negedge clk_25m);
        rst = 1'b1;
        @(negedge clk_25m);
        rst = 1'b0;
        model_reset();
        check_all("rst_over");

        hit_pulse("hit_mid");
        for (int i = 0; i < 30; i++) rnd_frame("dead30", 1);
        @(negedge clk_25m);
        rst = 1'b1;
        @(negedge clk_25m);
        rst = 1'b0;
        model_reset();
        check_all("rst_dead");
        for (int i = 0; i < 4; i++) rnd_frame("after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reimu_ctrl.md
Name: reimu_ctrl

Overview:
- Player-state stage directly upstream of the VGA pixel mux. Produces the player centre position (reimux, reimuy) and the visibility flag reimuE that the pixel mux uses to overlay the 30x50 player sprite.
- Moves the player from board buttons once per video frame, only during vertical blank, so the coordinates are stable while visible pixels are drawn.
- Owns the lives / death / respawn-invulnerability state machine.

Parameters:
- SPEED_FAST, 4: pixels moved per frame per axis, normal mode.
- SPEED_SLOW, 2: pixels moved per frame per axis while btn_slow is held.
- START_X, 320: spawn x (centre).
- START_Y, 400: spawn y (centre).
- DEAD_FRAMES, 60: frames the player stays hidden after a hit.
- INVULN_FRAMES, 120: frames of post-respawn invulnerability.
- BLINK_FRAMES, 8: frames per reimuE toggle during invulnerability.
- LIVES_INIT, 3: lives at reset (1..3).

Ports:
- clk_25m  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hc  in  10  current VGA column
- vc  in  10  current VGA row
- btn_up  in  1  raw button, asynchronous
- btn_down  in  1  raw button, asynchronous
- btn_left  in  1  raw button, asynchronous
- btn_right  in  1  raw button, asynchronous
- btn_slow  in  1  raw button, asynchronous
- hit  in  1  collision indication from the collision block, level, synchronous
- reimux  out  10  player centre x
- reimuy  out  10  player centre y
- reimuE  out  1  player visible
- lives  out  2  remaining lives
- invuln  out  1  high in INVULN state
- game_over  out  1  high in OVER state

Behaviour:
- Reset (rst sampled high on a clk_25m edge):
  - reimux=START_X, reimuy=START_Y, reimuE=1, lives=LIVES_INIT.
  - invuln=0, game_over=0, state ALIVE, frame counter 0, synchronizers cleared.
  - Reset mid-operation, including mid-DEAD or mid-INVULN, fully restarts the block.
- Button inputs:
  - Each btn_* passes through a 2-flop synchronizer.
  - Only synchronized values are used.
- Frame tick:
  - frame_tick is registered. It is high for exactly one cycle, the cycle after hc==0 && vc==480 is sampled.
  - All movement and frame counters update only on edges where frame_tick=1.
  - Position outputs change 2 cycles after the hc=0, vc=480 sample, i.e. inside vertical blank.
- Movement, on frame_tick in states ALIVE or INVULN:
  - step = btn_slow ? SPEED_SLOW : SPEED_FAST.
  - x delta: -step if left only, +step if right only, 0 if both or neither. y is the same with up = -step and down = +step.
  - Compute in 11-bit signed, then clamp x to [15,624] and y to [25,455]. This gives saturation with no wrap-around.
  - Diagonal moves apply both axes with no normalisation.
- State machine (ALIVE, DEAD, INVULN, OVER):
  - ALIVE: reimuE=1.
    - hit=1 on any edge with lives>1: next cycle goes to DEAD, lives decrements, reimuE=0, counter=0.
    - hit=1 with lives==1: go to OVER, lives=0.
  - DEAD: reimuE=0, no movement, hit ignored. Counter increments per frame_tick.
    - On the tick where counter reaches DEAD_FRAMES-1: reimux/reimuy load START_X/START_Y, go to INVULN, counter=0, reimuE=1.
  - INVULN: invuln=1, movement allowed, hit ignored. Counter increments per frame_tick.
    - reimuE toggles each time counter mod BLINK_FRAMES wraps to 0, starting visible.
    - On the tick where counter reaches INVULN_FRAMES-1: go to ALIVE, reimuE=1, invuln=0.
  - OVER: reimuE=0, game_over=1, position frozen, hit ignored. Exit is by rst only.
- Edge cases:
  - A hit in ALIVE coinciding with frame_tick: the hit wins and no movement is applied that frame.
  - Counter width is sized for max(DEAD_FRAMES, INVULN_FRAMES).

Optional Feature:
- Macro: REIMU_BLINK_EN.
- Defined: reimuE blinks during INVULN as described above.
- Undefined: reimuE holds 1 throughout INVULN, and the blink logic is not synthesized. The invuln output and all timing are unchanged.

Decomposition:
- Shared package holds:
  - state encoding constants (ALIVE, DEAD, INVULN, OVER);
  - screen geometry constants H_ACTIVE=640, V_ACTIVE=480;
  - sprite half-sizes 15 and 25;
  - derived clamp bounds X_MIN/X_MAX/Y_MIN/Y_MAX.
- The pixel mux reuses the same half-size constants.
- One natural sub-module, btn_sync, a parameterised-width 2-flop synchronizer instantiated once for the 5 buttons.

Test Plan:
- Reset, then 3 frames with right held and slow released -> reimux 320->324->328->332; reimuy stays 400; reimuE=1; outputs change only 2 cycles after (hc=0, vc=480).
- Start at x=322, hold left+slow for 200 frames -> x decreases by 2 per frame, saturates at 15, never wraps; up+down held together -> y unchanged.
- lives=3, pulse hit for 1 cycle in ALIVE -> next cycle reimuE=0, lives=2; after 60 frame_ticks position=(320,400), invuln=1; hit asserted during DEAD and INVULN -> ignored.
- INVULN with REIMU_BLINK_EN -> reimuE pattern: 8 frames on, 8 off, repeated; after 120 ticks ALIVE with reimuE=1. Without the macro -> reimuE constantly 1.
- Three hits separated by full respawn cycles -> after the third hit lives=0, game_over=1, reimuE=0, buttons have no effect; rst -> full restart values.
- Assert rst mid-DEAD (tick 30) -> next cycle ALIVE, lives=3, position (320,400), reimuE=1.
